// File: rtl/l1v_yanitlayici.sv
`default_nettype none
// ============================================================================
//  Module   : l1v_yanitlayici
//  Purpose  : l1v responder backed by a word-addressed RAM with a programmable
//             access latency; reads answer on a valid/ready data channel.
//  Revision : 1.0  initial release
// ============================================================================
module l1v_yanitlayici #(
    parameter int ADRES_BIT      = 32,
    parameter int VERI_BIT       = 32,
    parameter int DERINLIK       = 4096,
    parameter int GECIKME        = 2,
    parameter int ONBELLEKSIZ_EK = 4,
    parameter int VERI_BYTE      = VERI_BIT / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] istek_adres_i,
    input  logic                 istek_gecerli_i,
    input  logic                 istek_onbellekleme_i,
    input  logic                 istek_yaz_i,
    input  logic [VERI_BIT-1:0]  istek_veri_i,
    input  logic [VERI_BYTE-1:0] istek_maske_i,
    output logic                 istek_hazir_o,
    output logic [VERI_BIT-1:0]  veri_o,
    output logic                 veri_gecerli_o,
    input  logic                 veri_hazir_i
);

    localparam int         c_idx_bit          = $clog2(DERINLIK);
    localparam logic [4:0] c_gecikme          = 5'(GECIKME);
    localparam logic [4:0] c_onbelleksiz_ek   = 5'(ONBELLEKSIZ_EK);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        YANIT = 2'd2
    } durum_t;

    durum_t                 r_durum, w_durum_sonraki;
    logic [4:0]             r_sayac, w_sayac_sonraki;
    logic                   r_yaz;
    logic [c_idx_bit-1:0]   r_idx;
    logic [VERI_BIT-1:0]    r_veri;
    logic [VERI_BYTE-1:0]   r_maske;
    logic [VERI_BIT-1:0]    r_okunan;
    logic [VERI_BIT-1:0]    r_ram [DERINLIK];

    logic                   w_kabul;
    logic                   w_isle;
    logic [4:0]             w_bekleme;
    logic                   w_yaz;
    logic [c_idx_bit-1:0]   w_idx;
    logic [VERI_BIT-1:0]    w_veri;
    logic [VERI_BYTE-1:0]   w_maske;
    logic                   w_unused_adres;

    // Low byte-offset bits and aliasing upper bits are deliberately dropped.
    assign w_unused_adres = ^istek_adres_i;

    assign istek_hazir_o  = (r_durum == BOSTA) && !rst_i;
    assign w_kabul        = istek_gecerli_i && istek_hazir_o;
    assign w_bekleme      = istek_onbellekleme_i ? c_gecikme : (c_gecikme + c_onbelleksiz_ek);
    assign veri_gecerli_o = (r_durum == YANIT);
    assign veri_o         = r_okunan;

    // A zero-latency access acts in the accept cycle, so it must see the live inputs.
    assign w_yaz   = (r_durum == BOSTA) ? istek_yaz_i : r_yaz;
    assign w_idx   = (r_durum == BOSTA) ? istek_adres_i[c_idx_bit+1:2] : r_idx;
    assign w_veri  = (r_durum == BOSTA) ? istek_veri_i : r_veri;
    assign w_maske = (r_durum == BOSTA) ? istek_maske_i : r_maske;

    always_comb begin
        w_durum_sonraki = r_durum;
        w_sayac_sonraki = r_sayac;
        w_isle          = 1'b0;
        case (r_durum)
            BOSTA: begin
                if (w_kabul) begin
                    if (w_bekleme == 5'd0) begin
                        w_isle          = 1'b1;
                        w_durum_sonraki = istek_yaz_i ? BOSTA : YANIT;
                    end else begin
                        w_durum_sonraki = BEKLE;
                        w_sayac_sonraki = w_bekleme - 5'd1;
                    end
                end
            end
            BEKLE: begin
                if (r_sayac == 5'd0) begin
                    w_isle          = 1'b1;
                    w_durum_sonraki = r_yaz ? BOSTA : YANIT;
                end else begin
                    w_sayac_sonraki = r_sayac - 5'd1;
                end
            end
            YANIT: begin
                if (veri_hazir_i) begin
                    w_durum_sonraki = BOSTA;
                end
            end
            default: begin
                w_durum_sonraki = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum  <= BOSTA;
            r_sayac  <= 5'd0;
            r_okunan <= '0;
            r_yaz    <= 1'b0;
            r_idx    <= '0;
            r_veri   <= '0;
            r_maske  <= '0;
        end else begin
            r_durum <= w_durum_sonraki;
            r_sayac <= w_sayac_sonraki;
            if (w_kabul) begin
                r_yaz   <= istek_yaz_i;
                r_idx   <= istek_adres_i[c_idx_bit+1:2];
                r_veri  <= istek_veri_i;
                r_maske <= istek_maske_i;
            end
            if (w_isle && !w_yaz) begin
                r_okunan <= r_ram[w_idx];
            end
        end
    end

    // RAM keeps its contents across reset; a reset in the action cycle cancels the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_isle && w_yaz) begin
            for (int b = 0; b < VERI_BYTE; b++) begin
                if (w_maske[b]) begin
                    r_ram[w_idx][b*8 +: 8] <= w_veri[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
